// File: rtl/md_sequencer.sv
// Multiply/divide sequencer: owns HI/LO, holds mult/div results for a fixed
// latency and reports busy/stall to the hazard unit.
module md_sequencer #(
  parameter int unsigned MULT_LAT = 5,
  parameter int unsigned DIV_LAT  = 10
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        start,
  input  logic [2:0]  op,
  input  logic [31:0] rs_data,
  input  logic [31:0] rt_data,
  input  logic        md_use_D,
  output logic [31:0] hi,
  output logic [31:0] lo,
  output logic        busy,
  output logic        stall_req
);

  localparam int unsigned CNT_W    = 4;
  localparam logic [CNT_W-1:0] MULT_CNT = CNT_W'(MULT_LAT);
  localparam logic [CNT_W-1:0] DIV_CNT  = CNT_W'(DIV_LAT);

  localparam logic [2:0] OP_MTHI = 3'b100;
  localparam logic [2:0] OP_MTLO = 3'b101;

  typedef enum logic {IDLE, RUN} state_t;

  state_t           state;
  logic [CNT_W-1:0] cnt;
  logic [31:0]      pend_hi;
  logic [31:0]      pend_lo;
  logic             pend_wr;

  logic        is_signed;
  logic        is_div;
  logic        div_zero;
  logic [63:0] prod;
  logic        dvd_neg;
  logic        dvs_neg;
  logic [31:0] dvd_mag;
  logic [31:0] dvs_mag;
  logic [31:0] quo_mag;
  logic [31:0] rem_mag;
  logic [31:0] quo;
  logic [31:0] rem;
  logic [31:0] res_hi;
  logic [31:0] res_lo;

  // Result of the operation presented this cycle, captured at the issue edge.
  always_comb begin
    is_signed = ~op[0];
    is_div    = op[1];
    div_zero  = (rt_data == 32'd0);
    prod      = 64'd0;
    if (is_signed)
      prod = {{32{rs_data[31]}}, rs_data} * {{32{rt_data[31]}}, rt_data};
    else
      prod = {32'd0, rs_data} * {32'd0, rt_data};

    // Signed divide goes through magnitudes; 0x80000000 / -1 wraps back to 0x80000000.
    dvd_neg = is_signed & rs_data[31];
    dvs_neg = is_signed & rt_data[31];
    dvd_mag = dvd_neg ? (32'd0 - rs_data) : rs_data;
    dvs_mag = div_zero ? 32'd1 : (dvs_neg ? (32'd0 - rt_data) : rt_data);
    quo_mag = dvd_mag / dvs_mag;
    rem_mag = dvd_mag % dvs_mag;
    quo     = (dvd_neg ^ dvs_neg) ? (32'd0 - quo_mag) : quo_mag;
    rem     = dvd_neg ? (32'd0 - rem_mag) : rem_mag;

    res_hi = is_div ? rem : prod[63:32];
    res_lo = is_div ? quo : prod[31:0];
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state   <= IDLE;
      cnt     <= '0;
      pend_hi <= '0;
      pend_lo <= '0;
      pend_wr <= 1'b0;
      hi      <= '0;
      lo      <= '0;
      busy    <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (start) begin
            if (!op[2]) begin
              state   <= RUN;
              busy    <= 1'b1;
              cnt     <= is_div ? DIV_CNT : MULT_CNT;
              pend_hi <= res_hi;
              pend_lo <= res_lo;
              pend_wr <= ~(is_div & div_zero);
            end else if (op == OP_MTHI) begin
              hi <= rs_data;
            end else if (op == OP_MTLO) begin
              lo <= rs_data;
            end
          end
        end
        RUN: begin
          // Any start seen here is dropped; the hazard unit should never allow it.
          if (cnt == CNT_W'(1)) begin
            state <= IDLE;
            busy  <= 1'b0;
            cnt   <= '0;
            if (pend_wr) begin
              hi <= pend_hi;
              lo <= pend_lo;
            end
          end else begin
            cnt <= cnt - CNT_W'(1);
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  assign stall_req = md_use_D & (busy | (start & ~op[2]));

endmodule

// File: tb/tb_md_sequencer.sv
// Self-checking bench for md_sequencer: table of issue vectors with a result
// scoreboard, plus hand-written ignore/stall/reset sequences.
module tb_md_sequencer;

  localparam int unsigned MULT_LAT = 5;
  localparam int unsigned DIV_LAT  = 10;

  logic        clk;
  logic        reset;
  logic        start;
  logic [2:0]  op;
  logic [31:0] rs_data;
  logic [31:0] rt_data;
  logic        md_use_D;
  logic [31:0] hi;
  logic [31:0] lo;
  logic        busy;
  logic        stall_req;

  md_sequencer #(.MULT_LAT(MULT_LAT), .DIV_LAT(DIV_LAT)) dut (
    .clk(clk), .reset(reset), .start(start), .op(op),
    .rs_data(rs_data), .rt_data(rt_data), .md_use_D(md_use_D),
    .hi(hi), .lo(lo), .busy(busy), .stall_req(stall_req)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [2:0]  op;
    logic [31:0] a;
    logic [31:0] b;
    int          lat;
    logic [31:0] ehi;
    logic [31:0] elo;
  } vec_t;

  typedef struct {
    logic [31:0] hi;
    logic [31:0] lo;
  } exp_t;

  vec_t vecs[12];
  exp_t sb[$];
  int n_cmp = 0;
  int n_err = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic pop_chk(input string name);
    exp_t e;
    if (sb.size() == 0) begin
      n_cmp++;
      n_err++;
      $display("FAIL %s: scoreboard empty", name);
    end else begin
      e = sb.pop_front();
      chk({name, " hi"}, hi, e.hi);
      chk({name, " lo"}, lo, e.lo);
    end
  endtask

  // Issue one op, count busy cycles, then compare HI/LO against the scoreboard.
  task automatic run_op(input string name, input logic [2:0] o, input logic [31:0] a,
                        input logic [31:0] b, input int lat,
                        input logic [31:0] ehi, input logic [31:0] elo);
    int cnt;
    @(negedge clk);
    start = 1'b1; op = o; rs_data = a; rt_data = b;
    sb.push_back('{ehi, elo});
    @(negedge clk);
    start = 1'b0;
    cnt = 0;
    while (busy && cnt < 40) begin
      cnt++;
      @(negedge clk);
    end
    chk({name, " busy cycles"}, 32'(cnt), 32'(lat));
    pop_chk(name);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    int cnt;
    logic seen;

    vecs[0]  = '{3'b000, 32'hFFFFFFFD, 32'd5,       5,  32'hFFFFFFFF, 32'hFFFFFFF1};
    vecs[1]  = '{3'b001, 32'hFFFFFFFD, 32'd5,       5,  32'h00000004, 32'hFFFFFFF1};
    vecs[2]  = '{3'b000, 32'hFFFFFFFF, 32'hFFFFFFFF, 5, 32'h00000000, 32'h00000001};
    vecs[3]  = '{3'b011, 32'd7,        32'd2,       10, 32'h00000001, 32'h00000003};
    vecs[4]  = '{3'b010, 32'hFFFFFFF9, 32'd2,       10, 32'hFFFFFFFF, 32'hFFFFFFFD};
    vecs[5]  = '{3'b010, 32'd7,        32'hFFFFFFFE, 10, 32'h00000001, 32'hFFFFFFFD};
    vecs[6]  = '{3'b011, 32'hFFFFFFFF, 32'd10,      10, 32'h00000005, 32'h19999999};
    vecs[7]  = '{3'b010, 32'h80000000, 32'hFFFFFFFF, 10, 32'h00000000, 32'h80000000};
    vecs[8]  = '{3'b100, 32'h00000011, 32'd0,       0,  32'h00000011, 32'h80000000};
    vecs[9]  = '{3'b101, 32'h00000022, 32'd0,       0,  32'h00000011, 32'h00000022};
    vecs[10] = '{3'b010, 32'h00001234, 32'd0,       10, 32'h00000011, 32'h00000022};
    vecs[11] = '{3'b110, 32'hDEADBEEF, 32'd3,       0,  32'h00000011, 32'h00000022};

    reset = 1'b0; start = 1'b0; op = 3'b000; rs_data = '0; rt_data = '0; md_use_D = 1'b0;
    repeat (2) @(negedge clk);
    chk("reset hi", hi, 32'd0);
    chk("reset lo", lo, 32'd0);
    chk("reset busy", 32'(busy), 32'd0);
    chk("reset stall", 32'(stall_req), 32'd0);
    reset = 1'b1;

    for (int i = 0; i < 12; i++)
      run_op($sformatf("vec%0d", i), vecs[i].op, vecs[i].a, vecs[i].b,
             vecs[i].lat, vecs[i].ehi, vecs[i].elo);

    // divu issued on busy cycle 2 of a mult must be dropped.
    @(negedge clk);
    start = 1'b1; op = 3'b000; rs_data = 32'd3; rt_data = 32'd4;
    sb.push_back('{32'd0, 32'd12});
    @(negedge clk);
    start = 1'b0;
    cnt = 0;
    while (busy && cnt < 40) begin
      cnt++;
      if (cnt == 2) begin
        start = 1'b1; op = 3'b011; rs_data = 32'd100; rt_data = 32'd7;
      end else begin
        start = 1'b0;
      end
      @(negedge clk);
    end
    start = 1'b0;
    chk("ignore busy cycles", 32'(cnt), 32'(MULT_LAT));
    pop_chk("ignore result");
    @(negedge clk);
    chk("ignore no re-extend", 32'(busy), 32'd0);

    // stall_req spans the issue cycle plus every busy cycle.
    @(negedge clk);
    md_use_D = 1'b1; start = 1'b1; op = 3'b010; rs_data = 32'd100; rt_data = 32'd7;
    sb.push_back('{32'd2, 32'd14});
    #1;
    cnt = stall_req ? 1 : 0;
    @(posedge clk);
    #1 start = 1'b0;
    for (int i = 0; i < 40; i++) begin
      @(negedge clk);
      if (!stall_req) break;
      cnt++;
    end
    chk("stall cycles", 32'(cnt), 32'(DIV_LAT + 1));
    chk("stall low at visible", 32'(stall_req), 32'd0);
    pop_chk("stall div");

    @(negedge clk);
    md_use_D = 1'b0; start = 1'b1; op = 3'b010; rs_data = 32'd9; rt_data = 32'd2;
    sb.push_back('{32'd1, 32'd4});
    #1 seen = stall_req;
    @(negedge clk);
    start = 1'b0;
    for (int i = 0; i < 12; i++) begin
      seen = seen | stall_req;
      @(negedge clk);
    end
    chk("no stall without md_use", 32'(seen), 32'd0);
    pop_chk("no stall div");

    // Asynchronous reset in the middle of a mult discards it.
    @(negedge clk);
    start = 1'b1; op = 3'b000; rs_data = 32'd6; rt_data = 32'd7;
    @(negedge clk);
    start = 1'b0;
    repeat (2) @(negedge clk);
    #2 reset = 1'b0;
    #1;
    chk("async reset busy", 32'(busy), 32'd0);
    chk("async reset hi", hi, 32'd0);
    chk("async reset lo", lo, 32'd0);
    @(negedge clk);
    reset = 1'b1;
    run_op("post reset mtlo", 3'b101, 32'd5, 32'd0, 0, 32'd0, 32'd5);
    repeat (8) @(negedge clk);
    chk("post reset lo held", lo, 32'd5);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

// File: doc/md_sequencer.md
Name: md_sequencer

Overview:
- Sequencing controller for the EX-stage multiply/divide resource.
- Accepts mult/multu/div/divu/mthi/mtlo issues from EX, owns the HI/LO registers, and holds results internally for a fixed latency.
- Drives busy and a stall request to the hazard unit, so that a mfhi/mflo/md-class instruction in ID waits until the result is architecturally visible.

Parameters:
- MULT_LAT, 5, busy cycles for mult/multu (legal 1..15)
- DIV_LAT, 10, busy cycles for div/divu (legal 1..15)

Ports:
- clk  input  1  system clock, rising edge
- reset  input  1  asynchronous, active-low reset
- start  input  1  EX instruction is md-class write (mult/multu/div/divu/mthi/mtlo) this cycle
- op  input  3  000 mult, 001 multu, 010 div, 011 divu, 100 mthi, 101 mtlo, others no-op
- rs_data  input  32  forwarded rs operand (EX)
- rt_data  input  32  forwarded rt operand (EX)
- md_use_D  input  1  instruction in ID reads or writes HI/LO (mult..mtlo, mfhi, mflo)
- hi  output  32  architectural HI
- lo  output  32  architectural LO
- busy  output  1  operation in flight
- stall_req  output  1  to hazard unit: stall F/D, flush E

Behaviour:
- Reset (reset=0, async): hi=0, lo=0, busy=0, state IDLE, counter=0, pending result=0. Any in-flight operation is discarded.
- FSM states:
  - IDLE -> RUN: on start with op 000..011.
  - RUN: counter decrements each edge. On the edge where counter==1, hi/lo <= pending result and state -> IDLE.
- Latency:
  - busy is high for exactly LAT cycles, beginning the cycle after the start cycle.
  - New hi/lo values are visible in the first cycle busy is low again.
- Issue capture at the start edge:
  - Operands are captured and the pending result is computed from the captured values.
  - counter <= MULT_LAT or DIV_LAT.
- mthi/mtlo:
  - Taken only in IDLE.
  - hi (or lo) <= rs_data at the next edge. No busy, no effect on the other register.
- start while in RUN:
  - Ignored entirely: no state change, no operand capture, hi/lo unaffected.
  - The hazard unit is required to prevent this case; the bench checks the ignore rule.
- Unused op codes (110, 111) with start: no-op, state unchanged.
- Arithmetic:
  - mult: {hi,lo} = signed 64-bit product.
  - multu: {hi,lo} = unsigned 64-bit product.
  - div: lo = quotient truncated toward zero; hi = remainder with the sign of the dividend (rs).
  - div special case: 0x80000000 / 0xFFFFFFFF gives lo=0x80000000, hi=0.
  - divu: unsigned quotient/remainder.
- Divide by zero (rt==0):
  - The operation still occupies DIV_LAT busy cycles.
  - hi/lo remain unchanged at completion.
- stall_req (combinational) = md_use_D & (busy | (start & op is 000..011)).
  - Result: an md-class instruction directly behind a mult/div stalls from the issue cycle until the result is visible.
- hi/lo outputs change only at: the completion edge, an mthi/mtlo edge, or reset.

Test Plan:
1. mult rs=0xFFFFFFFD (-3), rt=5 -> busy high 5 cycles; afterwards hi=0xFFFFFFFF, lo=0xFFFFFFF1. multu with the same operands -> hi=0x00000004, lo=0xFFFFFFF1.
2. divu 7/2 -> busy 10 cycles, then lo=3, hi=1. div -7/2 -> lo=0xFFFFFFFD, hi=0xFFFFFFFF. div 0x80000000/0xFFFFFFFF -> lo=0x80000000, hi=0.
3. Preload via mthi 0x11, mtlo 0x22 (each visible next cycle, no busy); then div by 0 -> 10 busy cycles, hi=0x11, lo=0x22 unchanged.
4. mult issued, then start with op divu on busy cycle 2 -> ignored; only the mult result appears after 5 cycles, busy never re-extends.
5. md_use_D=1 on the start cycle of a div -> stall_req high for 11 consecutive cycles (start cycle + 10 busy), low in the cycle new lo is visible; md_use_D=0 -> stall_req stays 0.
6. reset pulled low on busy cycle 3 of a mult -> busy=0, hi=lo=0 immediately (asynchronous). After release, an mtlo 0x5 issue works normally: lo=0x5 next cycle.
